// File: rtl/unit_clause_sched.sv
// unit_clause_sched
//   Drives one BCP round. It repeatedly takes the lowest-index pending unit
//   clause from the unit-clause register and offers it to the implication
//   engine. When the engine reports success, it deletes that clause from the
//   register with a one-cycle masked-delete strobe. The round ends when no unit
//   clause is left, or when the engine reports a conflict.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   start, abort      start a round (sampled only in IDLE) / synchronous abort
//   unit_clause       current contents of the unit-clause register
//   issue_valid/_idx  clause offered to the implication engine
//   issue_ready       the implication engine accepts the offered clause
//   imply_done        one-cycle pulse: the implication has finished
//   imply_conflict    qualifies imply_done: the implication hit a conflict
//   rw_en             masked-delete strobe to the unit-clause register
//   delete_unit       AND-mask for the register (all ones unless rw_en is high)
//   busy, bcp_done    round in progress / one-cycle end-of-round pulse
//   bcp_conflict      result of the last round
//   prop_cnt          successful propagations in the current round (saturates)
//   dbg_state         current FSM state, for debug and checkers
//
// Handshake: an issue is transferred on a cycle where issue_valid and
// issue_ready are both high. issue_valid holds, and issue_idx stays stable,
// until that transfer happens. issue_valid never depends on issue_ready.
module unit_clause_sched #(
   parameter int CLAUSE_NUM = 8,
   parameter int IDX_W      = $clog2(CLAUSE_NUM),
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [CLAUSE_NUM-1:0] unit_clause,
   output logic                  issue_valid,
   output logic [IDX_W-1:0]      issue_idx,
   input  logic                  issue_ready,
   input  logic                  imply_done,
   input  logic                  imply_conflict,
   output logic                  rw_en,
   output logic [CLAUSE_NUM-1:0] delete_unit,
   output logic                  busy,
   output logic                  bcp_done,
   output logic                  bcp_conflict,
   output logic [CNT_W-1:0]      prop_cnt,
   output logic [2:0]            dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SCAN   = 3'd1,
      S_ISSUE  = 3'd2,
      S_WAIT   = 3'd3,
      S_CLEAR  = 3'd4,
      S_SETTLE = 3'd5,
      S_FINISH = 3'd6
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [IDX_W-1:0]     r_idx;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_conf;
   logic                 w_any;
   logic [IDX_W-1:0]     w_low;

   // Lowest set bit. The loop runs from the top bit down, so the last match,
   // which is the lowest index, is the one that remains.
   always_comb begin
      w_any = |unit_clause;
      w_low = '0;
      for (int i = CLAUSE_NUM - 1; i >= 0; i--) begin
         if (unit_clause[i]) w_low = IDX_W'(i);
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; abort overrides every transition
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_SCAN;
         S_SCAN:   w_next = w_any ? S_ISSUE : S_FINISH;
         S_ISSUE:  if (issue_ready) w_next = S_WAIT;
         S_WAIT:   if (imply_done) w_next = imply_conflict ? S_FINISH : S_CLEAR;
         S_CLEAR:  w_next = S_SETTLE;
         S_SETTLE: w_next = S_SCAN;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      if (abort) w_next = S_IDLE;
   end

   // The index is captured only in SCAN. Backpressure in ISSUE therefore
   // cannot move it, even if the register contents change meanwhile.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                r_idx <= '0;
      else if (r_state == S_SCAN && w_any && !abort) r_idx <= w_low;
   end

   // Round bookkeeping. Abort freezes both the count and the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_conf <= 1'b0;
      end else if (!abort) begin
         if (r_state == S_IDLE && start) begin
            r_cnt  <= '0;
            r_conf <= 1'b0;
         end
         if (r_state == S_CLEAR && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
         if (r_state == S_WAIT && imply_done && imply_conflict) r_conf <= 1'b1;
         if (r_state == S_SCAN && !w_any) r_conf <= 1'b0;
      end
   end

   // Output decode: uses only registered state and registered index
   always_comb begin
      issue_valid = (r_state == S_ISSUE);
      rw_en       = (r_state == S_CLEAR);
      busy        = (r_state != S_IDLE);
      bcp_done    = (r_state == S_FINISH);
      delete_unit = {CLAUSE_NUM{1'b1}};
      if (r_state == S_CLEAR) delete_unit = ~({{(CLAUSE_NUM-1){1'b0}}, 1'b1} << r_idx);
   end

   assign issue_idx    = r_idx;
   assign prop_cnt     = r_cnt;
   assign bcp_conflict = r_conf;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_unit_clause_sched.sv
// Bench for unit_clause_sched (CLAUSE_NUM = 8). The reference model is the
// unit-clause register kept as a byte. At each step it picks the lowest
// pending bit, expects the fixed round latencies, and applies each
// delete to its own copy of the register.
module tb_unit_clause_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  unit_clause;
  logic        issue_valid;
  logic [2:0]  issue_idx;
  logic        issue_ready;
  logic        imply_done;
  logic        imply_conflict;
  logic        rw_en;
  logic [7:0]  delete_unit;
  logic        busy;
  logic        bcp_done;
  logic        bcp_conflict;
  logic [15:0] prop_cnt;
  logic [2:0]  dbg_state;

  int n_chk;
  int n_pass;
  logic [7:0] m_reg;
  int exp_prop;

  unit_clause_sched #(.CLAUSE_NUM(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .unit_clause(unit_clause), .issue_valid(issue_valid), .issue_idx(issue_idx),
    .issue_ready(issue_ready), .imply_done(imply_done), .imply_conflict(imply_conflict),
    .rw_en(rw_en), .delete_unit(delete_unit), .busy(busy), .bcp_done(bcp_done),
    .bcp_conflict(bcp_conflict), .prop_cnt(prop_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Outputs are sampled 1 time unit after each rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(issue_valid), 32'd0);
    chk({tag, "_idx"},   32'(issue_idx),   32'd0);
    chk({tag, "_rw"},    32'(rw_en),       32'd0);
    chk({tag, "_mask"},  32'(delete_unit), 32'hff);
    chk({tag, "_busy"},  32'(busy),        32'd0);
    chk({tag, "_done"},  32'(bcp_done),    32'd0);
    chk({tag, "_conf"},  32'(bcp_conflict),32'd0);
    chk({tag, "_cnt"},   32'(prop_cnt),    32'd0);
  endtask

  // One round. conf_at / abort_at: the propagation number (0-based) that
  // conflicts or is aborted in ISSUE, or -1 for neither. rdy_fix / done_fix:
  // fixed delays, or -1 for random delays. bp_set: bits that appear in the
  // register during backpressure.
  task automatic run_round(input logic [7:0] init, input int conf_at, input int abort_at,
                           input int rdy_fix, input int done_fix, input logic [7:0] bp_set);
    int k;
    int idx;
    int rd;
    int dd;
    bit fin;
    logic [7:0] exp_mask;
    m_reg = init;
    unit_clause = m_reg;
    exp_prop = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("scan_busy", 32'(busy), 32'd1);
    chk("scan_valid", 32'(issue_valid), 32'd0);
    step();
    k = 0;
    fin = 0;
    while (!fin) begin
      if (m_reg == 8'd0) begin
        chk("done_pulse", 32'(bcp_done), 32'd1);
        chk("done_noissue", 32'(issue_valid), 32'd0);
        chk("done_conf", 32'(bcp_conflict), 32'd0);
        chk("done_cnt", 32'(prop_cnt), 32'(exp_prop));
        step();
        chk("after_done_busy", 32'(busy), 32'd0);
        chk("after_done_pulse", 32'(bcp_done), 32'd0);
        fin = 1;
      end else begin
        idx = lowest(m_reg);
        chk("issue_valid", 32'(issue_valid), 32'd1);
        chk("issue_idx", 32'(issue_idx), 32'(idx));
        chk("issue_nodone", 32'(bcp_done), 32'd0);
        if (k == abort_at) begin
          start = 1'b1;            // stray start while busy
          step();
          start = 1'b0;
          chk("stray_start_valid", 32'(issue_valid), 32'd1);
          chk("stray_start_idx", 32'(issue_idx), 32'(idx));
          abort = 1'b1;
          step();
          abort = 1'b0;
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_done", 32'(bcp_done), 32'd0);
          chk("abort_cnt", 32'(prop_cnt), 32'(exp_prop));
          chk("abort_conf", 32'(bcp_conflict), 32'd0);
          step();
          chk("abort_nodone", 32'(bcp_done), 32'd0);
          fin = 1;
        end else begin
          rd = (rdy_fix >= 0) ? rdy_fix : int'($urandom_range(0, 3));
          dd = (done_fix >= 0) ? done_fix : int'($urandom_range(0, 3));
          issue_ready = 1'b0;
          for (int c = 0; c < rd; c++) begin
            if (c == 0) begin
              m_reg = m_reg | bp_set;
              unit_clause = m_reg;
            end
            step();
            chk("bp_valid", 32'(issue_valid), 32'd1);
            chk("bp_idx", 32'(issue_idx), 32'(idx));
          end
          issue_ready = 1'b1;
          step();
          issue_ready = 1'b0;
          for (int c = 0; c < dd; c++) begin
            chk("wait_valid", 32'(issue_valid), 32'd0);
            chk("wait_rw", 32'(rw_en), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            imply_conflict = 1'($urandom_range(0, 1));   // ignored without imply_done
            step();
          end
          imply_done = 1'b1;
          imply_conflict = (k == conf_at);
          step();
          imply_done = 1'b0;
          imply_conflict = 1'b0;
          if (k == conf_at) begin
            chk("conf_done", 32'(bcp_done), 32'd1);
            chk("conf_flag", 32'(bcp_conflict), 32'd1);
            chk("conf_rw", 32'(rw_en), 32'd0);
            chk("conf_cnt", 32'(prop_cnt), 32'(exp_prop));
            step();
            chk("conf_idle", 32'(busy), 32'd0);
            chk("conf_hold", 32'(bcp_conflict), 32'd1);
            fin = 1;
          end else begin
            exp_mask = ~(8'd1 << idx);
            chk("clear_rw", 32'(rw_en), 32'd1);
            chk("clear_mask", 32'(delete_unit), 32'(exp_mask));
            m_reg = m_reg & exp_mask;
            unit_clause = m_reg;
            exp_prop++;
            step();
            chk("settle_rw", 32'(rw_en), 32'd0);
            chk("settle_mask", 32'(delete_unit), 32'hff);
            chk("settle_cnt", 32'(prop_cnt), 32'(exp_prop));
            step();
            chk("scan_valid2", 32'(issue_valid), 32'd0);
            step();
            k++;
          end
        end
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    unit_clause = 8'd0;
    issue_ready = 1'b0;
    imply_done = 1'b0;
    imply_conflict = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Asynchronous reset while waiting for the implication result
    m_reg = 8'h01;
    unit_clause = m_reg;
    start = 1'b1; step(); start = 1'b0;
    step();
    issue_ready = 1'b1; step(); issue_ready = 1'b0;
    chk("inwait_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(issue_valid), 32'd0);

    // Directed rounds
    run_round(8'b0010_0100, -1, -1, 0, 2, 8'h00);   // two units
    chk("two_units_cnt", 32'(prop_cnt), 32'd2);
    run_round(8'h00, -1, -1, 0, 0, 8'h00);          // empty round
    run_round(8'b1000_0000, 0, -1, 0, 1, 8'h00);    // conflict
    // stray imply_done in IDLE is ignored
    imply_done = 1'b1; imply_conflict = 1'b0; step(); imply_done = 1'b0;
    chk("stray_done_busy", 32'(busy), 32'd0);
    chk("stray_done_pulse", 32'(bcp_done), 32'd0);
    chk("stray_done_conf", 32'(bcp_conflict), 32'd1);
    run_round(8'b0000_1000, -1, -1, 5, 1, 8'b0000_0010);  // backpressure
    run_round(8'h16, -1, 1, 1, 1, 8'h00);           // abort after one propagation

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      int ca;
      int ab;
      logic [7:0] bp;
      ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      bp = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      run_round(8'($urandom_range(0, 255)), ca, ab, -1, -1, bp);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
